// File: rtl/bus_master_if_pkg.sv
// Shared encodings for the master-side bus interface: FSM states, bus direction and enable levels.
package bus_master_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_ACCESS = 2'b10
    } state_t;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;
    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;

    // The master asserts bus_req for the whole time it is between accept and completion.
    function automatic logic owns_bus(input state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/bus_master_if_if.sv
// Shared-bus signal bundle between one master and the arbiter/slave side.
interface bus_master_if_if #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 32
);
    logic              bus_req;
    logic              bus_grnt;
    logic              bus_as;
    logic              bus_rw;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_rdy;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_as, bus_rw, bus_addr, bus_wdata,
        input  bus_grnt, bus_rdy, bus_rdata
    );

    modport slave (
        input  bus_req, bus_as, bus_rw, bus_addr, bus_wdata,
        output bus_grnt, bus_rdy, bus_rdata
    );
endinterface

// File: rtl/bus_master_if_watchdog.sv
// Access watchdog: counts cycles while enabled, expire is high on the LIMIT-th enabled cycle.
// Latency: expire is combinational from the count; load clears the count on the next edge.
// Backpressure: none, the owner decides what to do with expire.
module bus_watchdog #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);
    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign expire = enable && (cnt == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/bus_master_if.sv
// Master-side shared-bus interface: one local request -> request/grant/strobe/ready sequence -> one response pulse.
// Latency: 3 cycles accept-to-response minimum; BUS_TIMEOUT_EN adds an ACCESS watchdog of TIMEOUT cycles.
// Backpressure: req_ready only in IDLE, no queueing; bus outputs are zero when not driving an access.
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    bus_master_if_if.master   bus
);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("bus_master_if: TIMEOUT must be within 2..65535");
    end

    state_t            state;
    state_t            state_n;
    logic              lat_rw;
    logic              lat_rw_n;
    logic [ADDR_W-1:0] lat_addr;
    logic [ADDR_W-1:0] lat_addr_n;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] lat_wdata_n;
    logic              rsp_valid_n;
    logic              rsp_err_n;
    logic [DATA_W-1:0] rsp_rdata_n;
    logic              wd_expire;

`ifdef BUS_TIMEOUT_EN
    bus_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .load   (state != ST_ACCESS),
        .enable (state == ST_ACCESS),
        .expire (wd_expire)
    );
`else
    assign wd_expire = DISABLE;
`endif

    assign req_ready = (state == ST_IDLE) && !reset;

    always_comb begin
        state_n     = state;
        lat_rw_n    = lat_rw;
        lat_addr_n  = lat_addr;
        lat_wdata_n = lat_wdata;
        rsp_valid_n = DISABLE;
        rsp_err_n   = DISABLE;
        rsp_rdata_n = '0;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_n     = ST_REQ;
                    lat_rw_n    = req_rw;
                    lat_addr_n  = req_addr;
                    lat_wdata_n = req_wdata;
                end
            end
            ST_REQ: begin
                if (bus.bus_grnt) begin
                    state_n = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // A ready slave completes the access even if ownership or the watchdog ends in the same cycle.
                if (bus.bus_rdy) begin
                    state_n     = ST_IDLE;
                    rsp_valid_n = ENABLE;
                    rsp_rdata_n = (lat_rw == BUS_READ) ? bus.bus_rdata : '0;
                end else if (!bus.bus_grnt || wd_expire) begin
                    state_n     = ST_IDLE;
                    rsp_valid_n = ENABLE;
                    rsp_err_n   = ENABLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            lat_rw        <= BUS_WRITE;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            rsp_valid     <= DISABLE;
            rsp_err       <= DISABLE;
            rsp_rdata     <= '0;
            bus.bus_req   <= DISABLE;
            bus.bus_as    <= DISABLE;
            bus.bus_rw    <= BUS_WRITE;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
        end else begin
            state         <= state_n;
            lat_rw        <= lat_rw_n;
            lat_addr      <= lat_addr_n;
            lat_wdata     <= lat_wdata_n;
            rsp_valid     <= rsp_valid_n;
            rsp_err       <= rsp_err_n;
            rsp_rdata     <= rsp_rdata_n;
            bus.bus_req   <= owns_bus(state_n);
            bus.bus_as    <= (state_n == ST_ACCESS);
            // ACCESS is only entered from REQ, so the latched request is already stable here.
            bus.bus_rw    <= (state_n == ST_ACCESS) ? lat_rw : BUS_WRITE;
            bus.bus_addr  <= (state_n == ST_ACCESS) ? lat_addr : '0;
            bus.bus_wdata <= ((state_n == ST_ACCESS) && (lat_rw == BUS_WRITE)) ? lat_wdata : '0;
        end
    end

endmodule
